// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Bit-serial WIDTH-bit adder; one full adder reused LSB-first,
//            with valid/ready handshakes on the operand and result sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_shift;
  logic             carry, sum_bit, carry_out, last_bit;
  logic [CW-1:0]    cnt;

  always_comb begin
    sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    carry_out = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    last_bit  = (cnt == CW'(WIDTH - 1));
    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is LSB.
    res_shift            = res_sr >> 1;
    res_shift[WIDTH-1]   = sum_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = ADD;
      ADD:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_shift;
          carry  <= carry_out;
          // Counter parks at zero on the last bit instead of wrapping past WIDTH-1.
          cnt    <= last_bit ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == ADD);
  assign out_valid = (state == DONE);
  assign sum       = res_sr;
  assign cout      = carry;

endmodule

`default_nettype wire
